// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM states, data-bit
// encodings and oversampling sample points.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } uart_rx_state_e;

  localparam logic [1:0] DATA_BITS_5 = 2'd0;
  localparam logic [1:0] DATA_BITS_6 = 2'd1;
  localparam logic [1:0] DATA_BITS_7 = 2'd2;
  localparam logic [1:0] DATA_BITS_8 = 2'd3;

  localparam logic [3:0] SAMPLE_PT   = 4'd7;
  localparam logic [3:0] MAJ_PT0     = 4'd6;
  localparam logic [3:0] MAJ_PT1     = 4'd7;
  localparam logic [3:0] MAJ_PT2     = 4'd8;
  localparam logic [3:0] SAMPLE_WRAP = 4'd15;

  // Index of the last data bit for a given cfg_data_bits encoding (5..8 bits).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
    return {1'b0, data_bits} + 3'd4;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator: divisor down-counter with a synchronous
// realign input that restarts the period without issuing a tick.
module uart_baud_tick #(
  parameter int DIV_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  input  logic             realign,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (realign) begin
      cnt_d = div;
    end else if (cnt_q == '0) begin
      tick  = 1'b1;
      cnt_d = div;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled deframer for 5-8 data bits, optional parity,
// 1 or 2 stop bits. Define UART_RX_MAJORITY_EN for 3-sample majority voting.
//
// Output handshake: rx_valid is a single-cycle pulse with no ready/backpressure;
// rx_data, rx_parity_err and rx_frame_err are valid with it and hold until the
// next pulse.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int DIV_W = 12
) (
  input  logic             app_clk,
  input  logic             reset_n,
  input  logic             cfg_rx_en,
  input  logic [1:0]       cfg_data_bits,
  input  logic             cfg_stop_bits,
  input  logic             cfg_pen,
  input  logic             cfg_epen,
  input  logic [DIV_W-1:0] cfg_baud_div,
  input  logic             rxd,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_parity_err,
  output logic             rx_frame_err,
  output logic             rx_busy,
  output uart_rx_state_e   dbg_state
);

  logic           rxd_meta_q, rxd_meta_d;
  logic           rxd_s_q, rxd_s_d;
  logic           rxd_prev_q, rxd_prev_d;
  uart_rx_state_e state_q, state_d;
  logic [3:0]     samp_q, samp_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_err_q, par_err_d;
  logic           frm_err_q, frm_err_d;
  logic [7:0]     rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
  logic           rx_par_q, rx_par_d;
  logic           rx_frm_q, rx_frm_d;

  logic tick;
  logic start_det;
  logic decide;
  logic wrap;
  logic bit_val;
  logic par_exp;
  logic frm_now;

  assign start_det = (state_q == IDLE) && cfg_rx_en && rxd_prev_q && !rxd_s_q;
  assign wrap      = tick && (samp_q == SAMPLE_WRAP);
  assign par_exp   = cfg_epen ? (^shift_q) : ~(^shift_q);
  assign frm_now   = frm_err_q | ~bit_val;

  uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
    .clk     (app_clk),
    .rst_n   (reset_n),
    .div     (cfg_baud_div),
    .realign (start_det),
    .tick    (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  logic s6_q, s6_d;
  logic s7_q, s7_d;

  assign decide  = tick && (samp_q == MAJ_PT2);
  assign bit_val = maj3(s6_q, s7_q, rxd_s_q);

  always_comb begin
    s6_d = s6_q;
    s7_d = s7_q;
    if (tick && (samp_q == MAJ_PT0)) s6_d = rxd_s_q;
    if (tick && (samp_q == MAJ_PT1)) s7_d = rxd_s_q;
  end

  always_ff @(posedge app_clk or negedge reset_n) begin
    if (!reset_n) begin
      s6_q <= 1'b1;
      s7_q <= 1'b1;
    end else begin
      s6_q <= s6_d;
      s7_q <= s7_d;
    end
  end
`else
  assign decide  = tick && (samp_q == SAMPLE_PT);
  assign bit_val = rxd_s_q;
`endif

  always_comb begin
    rxd_meta_d = rxd;
    rxd_s_d    = rxd_meta_q;
    rxd_prev_d = rxd_s_q;
    state_d    = state_q;
    samp_d     = tick ? samp_q + 4'd1 : samp_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_par_d   = rx_par_q;
    rx_frm_d   = rx_frm_q;

    // Disabling the receiver mid-frame drops the character silently.
    if (state_q != IDLE && !cfg_rx_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_det) begin
            state_d   = START;
            samp_d    = 4'd0;
            bit_idx_d = 3'd0;
            shift_d   = 8'd0;
            par_err_d = 1'b0;
            frm_err_d = 1'b0;
          end
        end
        START: begin
          if (decide && bit_val) state_d = IDLE;
          else if (wrap)         state_d = DATA;
        end
        DATA: begin
          if (decide) shift_d[bit_idx_q] = bit_val;
          if (wrap) begin
            if (bit_idx_q == last_bit_idx(cfg_data_bits)) state_d = cfg_pen ? PARITY : STOP1;
            else bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        PARITY: begin
          if (decide && (bit_val != par_exp)) par_err_d = 1'b1;
          if (wrap) state_d = STOP1;
        end
        STOP1: begin
          if (decide) begin
            frm_err_d = frm_now;
            if (!cfg_stop_bits) begin
              state_d    = IDLE;
              rx_valid_d = 1'b1;
              rx_data_d  = shift_q;
              rx_par_d   = par_err_q;
              rx_frm_d   = frm_now;
            end
          end else if (wrap && cfg_stop_bits) begin
            state_d = STOP2;
          end
        end
        STOP2: begin
          if (decide) begin
            frm_err_d  = frm_now;
            state_d    = IDLE;
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
            rx_par_d   = par_err_q;
            rx_frm_d   = frm_now;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge app_clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
      state_q    <= IDLE;
      samp_q     <= 4'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      rx_par_q   <= 1'b0;
      rx_frm_q   <= 1'b0;
    end else begin
      rxd_meta_q <= rxd_meta_d;
      rxd_s_q    <= rxd_s_d;
      rxd_prev_q <= rxd_prev_d;
      state_q    <= state_d;
      samp_q     <= samp_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_par_q   <= rx_par_d;
      rx_frm_q   <= rx_frm_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_par_q;
  assign rx_frame_err  = rx_frm_q;
  assign rx_busy       = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: a line driver builds frames from the
// configuration, and a scoreboard checks each received character.
module tb_uart_rx_core;
  import uart_rx_pkg::*;

  localparam int DIV_W = 12;

  logic             app_clk;
  logic             reset_n;
  logic             cfg_rx_en;
  logic [1:0]       cfg_data_bits;
  logic             cfg_stop_bits;
  logic             cfg_pen;
  logic             cfg_epen;
  logic [DIV_W-1:0] cfg_baud_div;
  logic             rxd;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_parity_err;
  logic             rx_frame_err;
  logic             rx_busy;
  uart_rx_state_e   dbg_state;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  longint cyc = 0;
  longint start_cyc = 0;
  longint last_valid_cyc = 0;
  logic [7:0] last_data = 8'd0;

  // {frame_err, parity_err, data}
  logic [9:0] exp_q[$];

  uart_rx_core #(.DIV_W(DIV_W)) dut (
    .app_clk       (app_clk),
    .reset_n       (reset_n),
    .cfg_rx_en     (cfg_rx_en),
    .cfg_data_bits (cfg_data_bits),
    .cfg_stop_bits (cfg_stop_bits),
    .cfg_pen       (cfg_pen),
    .cfg_epen      (cfg_epen),
    .cfg_baud_div  (cfg_baud_div),
    .rxd           (rxd),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_busy       (rx_busy),
    .dbg_state     (dbg_state)
  );

  // Clock and cycle counter
  initial app_clk = 1'b0;
  always #5 app_clk = ~app_clk;
  always @(posedge app_clk) cyc <= cyc + 1;

  // Scoreboard
  always @(negedge app_clk) begin
    if (rx_valid === 1'b1) begin
      logic [9:0] got;
      logic [9:0] exp;
      n_valid = n_valid + 1;
      last_valid_cyc = cyc;
      got = {rx_frame_err, rx_parity_err, rx_data};
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_char got=%h required=none", got);
      end else begin
        exp = exp_q.pop_front();
        last_data = exp[7:0];
        if (got !== exp) begin
          bad = bad + 1;
          $display("FAIL rx_char got={frm,par,data}=%h required=%h", got, exp);
        end
      end
    end
  end

  function automatic int bit_cycles();
    return 16 * (int'(cfg_baud_div) + 1);
  endfunction

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (bit_cycles()) @(negedge app_clk);
  endtask

  // Data bit with a one-tick pulse of the opposite level centred on count 7.
  task automatic drive_glitch_bit(input logic v);
    int t;
    int pre;
    t = int'(cfg_baud_div) + 1;
    pre = 8 * t - t / 2;
    rxd = v;
    repeat (pre) @(negedge app_clk);
    rxd = ~v;
    repeat (t) @(negedge app_clk);
    rxd = v;
    repeat (bit_cycles() - pre - t) @(negedge app_clk);
  endtask

  // Sends one frame with the current configuration and queues its expectation.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int glitch_bit);
    int nb;
    logic [7:0] dm;
    logic par;
    nb = int'(cfg_data_bits) + 5;
    dm = d & 8'((1 << nb) - 1);
    par = 1'b0;
    for (int i = 0; i < nb; i++) par = par ^ dm[i];
    if (!cfg_epen) par = ~par;
    par = par ^ bad_par;
    exp_q.push_back({bad_stop, cfg_pen & bad_par, dm});
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) begin
      if (i == glitch_bit) drive_glitch_bit(dm[i]);
      else drive_bit(dm[i]);
    end
    if (cfg_pen) drive_bit(par);
    drive_bit(~bad_stop);
    if (cfg_stop_bits) drive_bit(1'b1);
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic pen, input logic epen,
                         input logic stop2, input int div);
    cfg_data_bits = db;
    cfg_pen       = pen;
    cfg_epen      = epen;
    cfg_stop_bits = stop2;
    cfg_baud_div  = DIV_W'(div);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rxd = 1'b1;
    cfg_rx_en = 1'b1;
    set_cfg(DATA_BITS_8, 1'b0, 1'b0, 1'b0, 3);
    repeat (4) @(negedge app_clk);
    total = total + 1;
    if ({rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy} !== 12'd0) begin
      bad = bad + 1;
      $display("FAIL reset_outputs got=%h required=000",
               {rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy});
    end
    reset_n = 1'b1;
    repeat (4) @(negedge app_clk);
    total = total + 1;
    if (rx_busy !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL idle_busy got=%b required=0", rx_busy);
    end
  endtask

  task automatic test_basic_8n1();
    int base;
    longint lat;
    base = n_valid;
    set_cfg(DATA_BITS_8, 1'b0, 1'b0, 1'b0, 3);
    send_frame(8'hA5, 1'b0, 1'b0, -1);
    drive_bit(1'b1);
    lat = last_valid_cyc - start_cyc;
    total = total + 2;
    if (n_valid - base !== 1) begin
      bad = bad + 1;
      $display("FAIL basic_count got=%0d required=1", n_valid - base);
    end
    if (lat < 600 || lat > 616) begin
      bad = bad + 1;
      $display("FAIL basic_latency got=%0d required=608+-8", lat);
    end
  endtask

  task automatic test_parity();
    int base;
    base = n_valid;
    set_cfg(DATA_BITS_7, 1'b1, 1'b1, 1'b1, 3);
    send_frame(8'h55, 1'b1, 1'b0, -1);
    drive_bit(1'b1);
    send_frame(8'h2A, 1'b0, 1'b0, -1);
    drive_bit(1'b1);
    total = total + 1;
    if (n_valid - base !== 2) begin
      bad = bad + 1;
      $display("FAIL parity_count got=%0d required=2", n_valid - base);
    end
  endtask

  task automatic test_frame_break();
    int base;
    base = n_valid;
    set_cfg(DATA_BITS_8, 1'b0, 1'b0, 1'b0, 3);
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    repeat (3) drive_bit(1'b0);
    repeat (2) drive_bit(1'b1);
    total = total + 1;
    if (n_valid - base !== 1) begin
      bad = bad + 1;
      $display("FAIL break_count got=%0d required=1", n_valid - base);
    end
    send_frame(8'h81, 1'b0, 1'b0, -1);
    drive_bit(1'b1);
    total = total + 1;
    if (n_valid - base !== 2) begin
      bad = bad + 1;
      $display("FAIL after_break_count got=%0d required=2", n_valid - base);
    end
  endtask

  task automatic test_glitch();
    int base;
    bit busy_seen;
    base = n_valid;
    busy_seen = 1'b0;
    set_cfg(DATA_BITS_8, 1'b0, 1'b0, 1'b0, 3);
    rxd = 1'b0;
    repeat (2 * (int'(cfg_baud_div) + 1)) begin
      @(negedge app_clk);
      if (rx_busy === 1'b1) busy_seen = 1'b1;
    end
    rxd = 1'b1;
    repeat (2 * bit_cycles()) begin
      @(negedge app_clk);
      if (rx_busy === 1'b1) busy_seen = 1'b1;
    end
    total = total + 3;
    if (busy_seen !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL glitch_busy_pulse got=%b required=1", busy_seen);
    end
    if (rx_busy !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL glitch_busy_end got=%b required=0", rx_busy);
    end
    if (n_valid - base !== 0) begin
      bad = bad + 1;
      $display("FAIL glitch_count got=%0d required=0", n_valid - base);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = n_valid;
    set_cfg(DATA_BITS_5, 1'b0, 1'b0, 1'b0, 2);
    send_frame(8'h1F, 1'b0, 1'b0, -1);
    send_frame(8'h00, 1'b0, 1'b0, -1);
    send_frame(8'h15, 1'b0, 1'b0, -1);
    drive_bit(1'b1);
    total = total + 1;
    if (n_valid - base !== 3) begin
      bad = bad + 1;
      $display("FAIL b2b_count got=%0d required=3", n_valid - base);
    end
  endtask

  task automatic test_random();
    int base;
    int nfr;
    base = n_valid;
    nfr = 10;
    for (int k = 0; k < nfr; k++) begin
      set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 3));
      send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0), -1);
      repeat ($urandom_range(1, 2)) drive_bit(1'b1);
    end
    total = total + 1;
    if (n_valid - base !== nfr) begin
      bad = bad + 1;
      $display("FAIL random_count got=%0d required=%0d", n_valid - base, nfr);
    end
  endtask

  task automatic test_abort_en();
    int base;
    logic [7:0] held;
    base = n_valid;
    held = last_data;
    set_cfg(DATA_BITS_8, 1'b0, 1'b0, 1'b0, 3);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    cfg_rx_en = 1'b0;
    repeat (2) @(negedge app_clk);
    total = total + 1;
    if (rx_busy !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL abort_busy got=%b required=0", rx_busy);
    end
    repeat (4) drive_bit(1'b0);
    repeat (3) drive_bit(1'b1);
    cfg_rx_en = 1'b1;
    drive_bit(1'b1);
    total = total + 2;
    if (n_valid - base !== 0) begin
      bad = bad + 1;
      $display("FAIL abort_count got=%0d required=0", n_valid - base);
    end
    if (rx_data !== held) begin
      bad = bad + 1;
      $display("FAIL abort_data got=%h required=%h", rx_data, held);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    base = n_valid;
    set_cfg(DATA_BITS_8, 1'b1, 1'b0, 1'b0, 3);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rxd = 1'b0;
    repeat (5) @(negedge app_clk);
    reset_n = 1'b0;
    repeat (2) @(negedge app_clk);
    total = total + 1;
    if ({rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy} !== 12'd0) begin
      bad = bad + 1;
      $display("FAIL mid_reset_outputs got=%h required=000",
               {rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy});
    end
    rxd = 1'b1;
    repeat (4) @(negedge app_clk);
    reset_n = 1'b1;
    repeat (2) drive_bit(1'b1);
    total = total + 2;
    if (n_valid - base !== 0) begin
      bad = bad + 1;
      $display("FAIL mid_reset_count got=%0d required=0", n_valid - base);
    end
    if (rx_busy !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL mid_reset_busy got=%b required=0", rx_busy);
    end
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority_glitch();
    int base;
    base = n_valid;
    set_cfg(DATA_BITS_8, 1'b0, 1'b0, 1'b0, 3);
    send_frame(8'hC3, 1'b0, 1'b0, 2);
    drive_bit(1'b1);
    send_frame(8'h5A, 1'b0, 1'b0, 5);
    drive_bit(1'b1);
    total = total + 1;
    if (n_valid - base !== 2) begin
      bad = bad + 1;
      $display("FAIL majority_count got=%0d required=2", n_valid - base);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_8n1();
    test_parity();
    test_frame_break();
    test_glitch();
    test_back_to_back();
    test_random();
    test_abort_en();
    test_reset_mid_frame();
`ifdef UART_RX_MAJORITY_EN
    test_majority_glitch();
`endif
    repeat (10) @(negedge app_clk);
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL missing_chars got=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Synthesizable UART receiver for the chip's UART peripheral. It is the DUT-side partner of the bench UART agent's transmit path. It takes the serial line `rxd` asynchronously, oversamples it at 16x the baud rate, and deframes 5–8 data bits with optional parity and 1 or 2 stop bits. Each character is presented as a one-cycle valid pulse with per-character parity and framing error flags, for the register and FIFO layer above.

## Interface
Parameters:
- DIV_W, 12, width of the baud divisor.

Ports:
- app_clk  in  1  core clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_rx_en  in  1  receiver enable.
- cfg_data_bits  in  2  data bits per character: 0=5, 1=6, 2=7, 3=8.
- cfg_stop_bits  in  1  stop bits: 0=one, 1=two.
- cfg_pen  in  1  parity enable.
- cfg_epen  in  1  1=even parity, 0=odd parity.
- cfg_baud_div  in  DIV_W  16x tick period is cfg_baud_div+1 app_clk cycles.
- rxd  in  1  serial input, asynchronous; idles high.
- rx_data  out  8  received character, LSB first on the line; unused upper bits are 0.
- rx_valid  out  1  one-cycle pulse when a character completes.
- rx_parity_err  out  1  qualified by rx_valid.
- rx_frame_err  out  1  qualified by rx_valid; any sampled stop bit was low.
- rx_busy  out  1  high whenever state is not IDLE.

## Operation
- rxd passes through a 2-flop synchronizer whose flops reset to 1; all further logic uses the synchronized value rxd_s.
- Tick generator: a down-counter loaded with cfg_baud_div.
  - One tick is issued per reload.
  - The counter is forced to reload on start detection, so bit timing aligns to the start edge.
- Sample counter (4 bits) counts ticks within a bit:
  - cleared to 0 on start detection;
  - wraps 15→0 at each bit boundary.
- Decision point is count 7 (single sample).
- State machine:
  - IDLE: on a 1→0 transition of rxd_s while cfg_rx_en=1, go to START.
  - START: at the decision point, if rxd_s=1 it is a false start and the FSM returns to IDLE with no output. Otherwise, at the wrap, go to DATA.
  - DATA: shift the decided bit into bit index n, n=0..N-1. After bit N-1 wraps, go to PARITY if cfg_pen=1, else STOP1.
  - PARITY: expected bit is XOR(data) for even parity, ~XOR(data) for odd. A mismatch latches the parity error.
  - STOP1: a decided value of 0 latches the frame error. If cfg_stop_bits=0, complete at the decision point; else go to STOP2 at the wrap.
  - STOP2: same check as STOP1; complete at the decision point.
- Complete: on the cycle after the final decision,
  - rx_valid=1 for exactly one cycle;
  - rx_data and both error flags update together and hold until the next completion;
  - state returns to IDLE immediately, half a bit before the line frame ends.
- A break (line held low) cannot retrigger a start, because start detection requires a 1→0 transition.
- cfg_rx_en=0 during a frame: abort to IDLE on the next cycle; no rx_valid; rx_data is unchanged.
- cfg_* must stay static while rx_busy=1; behaviour otherwise is undefined.

## Timing
- Reset values:
  - rx_data=0, rx_valid=0, rx_parity_err=0, rx_frame_err=0, rx_busy=0;
  - state IDLE; synchronizer flops 1; counters 0.
- Start latency: falling edge on rxd to rx_busy=1 is 3 app_clk cycles (2 synchronizer cycles plus 1 register).
- One bit period is 16*(cfg_baud_div+1) cycles; cfg_baud_div=0 gives one tick per cycle.
- rx_valid asserts 1 cycle after the tick that carries the last stop-bit decision.
- Back-to-back frames with zero idle between them are received without loss.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - each bit is sampled at counts 6, 7 and 8;
  - the decided value is the majority of the three samples;
  - the decision point moves to count 8, and all states use it;
  - rx_valid shifts one tick later.
- Not defined: a single sample is taken at count 7 and the sample registers are absent.

## Structure
- Shared package uart_rx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP1, STOP2);
  - the data-bit encoding constants;
  - the sample-point constants (7, and 6/7/8).
- One sub-module, uart_baud_tick: divisor down-counter with a synchronous realign input and a tick output, reusable by the transmitter.

## Test plan
- cfg_baud_div=3, 8N1, agent sends 0xA5 → one rx_valid pulse with rx_data=0xA5 and both error flags 0. rx_valid occurs about 9.5 bit periods (608 cycles) after the start edge, ±8 cycles.
- 7 data bits, even parity, 2 stop bits, send 0x55 with wrong parity → rx_data=0x55 and rx_parity_err=1. Then send 0x2A with correct parity → rx_parity_err=0.
- 8N1 with stop bit forced low on 0x3C → rx_frame_err=1. Then hold the line low for 3 bit periods → no further rx_valid until the line returns high and a new start arrives.
- Glitch: 2 tick-periods low pulse on idle line → FSM returns to IDLE, no rx_valid, rx_busy pulses only.
- 5 data bits, back-to-back 0x1F, 0x00, 0x15 with no idle gap → three rx_valid pulses with rx_data=0x1F, 0x00, 0x15.
- Drop cfg_rx_en mid-DATA, and separately assert reset_n=0 mid-frame → FSM returns to IDLE, no rx_valid, outputs at reset values after reset. With UART_RX_MAJORITY_EN defined, a 1-tick glitch at count 7 of a data bit must not change the decoded byte.
